// File: rtl/dsp19x2_dual_lane_accumulator.sv
// Dual-lane frame accumulator behind a split-mode DSP19X2 pair.
// In: clk, reset(n), z_in/in_valid/in_ready, signed_mode, frame_len, clear; Out: acc1/acc2/sum, ovf1/2, out_valid/ready, overrun.
module dsp19x2_dual_lane_accumulator #(
  parameter int LANE_W = 19,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*LANE_W-1:0]   z_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  signed_mode,
  input  logic [CNT_W-1:0]      frame_len,
  input  logic                  clear,
  output logic [ACC_W-1:0]      acc1_out,
  output logic [ACC_W-1:0]      acc2_out,
  output logic [ACC_W:0]        sum_out,
  output logic                  ovf1,
  output logic                  ovf2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc1_q, acc1_d;
  logic [ACC_W-1:0]   acc2_q, acc2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
  logic               ovf1_q, ovf1_d;
  logic               ovf2_q, ovf2_d;
  logic               ovr_q, ovr_d;

  logic [LANE_W-1:0]  lane1, lane2;
  logic [CNT_W-1:0]   len_n;
  logic [ACC_W:0]     sat1, sat2;
  logic               start, add;

  function automatic logic [ACC_W-1:0] ext(
    input logic [LANE_W-1:0] v,
    input logic              s
  );
    logic [ACC_W-1:0] r;
    if (s) r = {{(ACC_W-LANE_W){v[LANE_W-1]}}, v};
    else   r = {{(ACC_W-LANE_W){1'b0}}, v};
    return r;
  endfunction

  // Result is {clamped, sum}; the sum is computed one bit wider
  // so the overflow condition can be read from the top bits.
  function automatic logic [ACC_W:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b,
    input logic             s
  );
    logic [ACC_W:0] w;
    logic [ACC_W:0] r;
    if (s) begin
      w = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (w[ACC_W] != w[ACC_W-1]) begin
        if (w[ACC_W]) r = {2'b11, {(ACC_W-1){1'b0}}};
        else          r = {2'b10, {(ACC_W-1){1'b1}}};
      end else begin
        r = {1'b0, w[ACC_W-1:0]};
      end
    end else begin
      w = {1'b0, a} + {1'b0, b};
      if (w[ACC_W]) r = {1'b1, {ACC_W{1'b1}}};
      else          r = {1'b0, w[ACC_W-1:0]};
    end
    return r;
  endfunction

  assign lane1 = z_in[2*LANE_W-1:LANE_W];
  assign lane2 = z_in[LANE_W-1:0];

  assign len_n = (frame_len == '0) ? CNT_W'(1) : frame_len;

  assign sat1 = sat_add(acc1_q, ext(lane1, mode_q), mode_q);
  assign sat2 = sat_add(acc2_q, ext(lane2, mode_q), mode_q);

  assign in_ready = (state_q != HOLD) || out_ready;

  always_comb begin
    state_d = state_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    ovf1_d  = ovf1_q;
    ovf2_d  = ovf2_q;
    ovr_d   = ovr_q;
    start   = 1'b0;
    add     = 1'b0;

    unique case (state_q)
      IDLE:  start = in_valid;
      ACCUM: add   = in_valid;
      HOLD: begin
        if (out_ready) begin
          if (in_valid) start   = 1'b1;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      mode_d  = signed_mode;
      len_d   = len_n;
      acc1_d  = ext(lane1, signed_mode);
      acc2_d  = ext(lane2, signed_mode);
      cnt_d   = CNT_W'(1);
      ovf1_d  = 1'b0;
      ovf2_d  = 1'b0;
      state_d = (len_n == CNT_W'(1)) ? HOLD : ACCUM;
    end

    if (add) begin
      acc1_d = sat1[ACC_W-1:0];
      acc2_d = sat2[ACC_W-1:0];
      ovf1_d = ovf1_q | sat1[ACC_W];
      ovf2_d = ovf2_q | sat2[ACC_W];
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_d == len_q) state_d = HOLD;
    end

    if (in_valid && !in_ready) ovr_d = 1'b1;

    // Flush beats everything, including a same-cycle transfer.
    if (clear) begin
      state_d = IDLE;
      acc1_d  = '0;
      acc2_d  = '0;
      cnt_d   = '0;
      ovf1_d  = 1'b0;
      ovf2_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc1_q  <= '0;
      acc2_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      ovf1_q  <= 1'b0;
      ovf2_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      ovf1_q  <= ovf1_d;
      ovf2_q  <= ovf2_d;
      ovr_q   <= ovr_d;
    end
  end

  assign acc1_out  = acc1_q;
  assign acc2_out  = acc2_q;
  assign ovf1      = ovf1_q;
  assign ovf2      = ovf2_q;
  assign overrun   = ovr_q;
  assign out_valid = (state_q == HOLD);

  // Full-width sum of the held lanes, extended per the frame's mode.
  assign sum_out = {mode_q & acc1_q[ACC_W-1], acc1_q}
                 + {mode_q & acc2_q[ACC_W-1], acc2_q};

endmodule

// File: doc/dsp19x2_dual_lane_accumulator.md
Name: dsp19x2_dual_lane_accumulator

Overview:
- Downstream consumer of a DSP19X2 pair operating in split (two 19-bit lane) mode, with input registers enabled and the output register disabled.
- Takes the packed 38-bit Z output and splits it into lane 1 (bits 37:19) and lane 2 (bits 18:0).
- Accumulates each lane over a programmable frame of samples with per-lane saturation.
- Presents both lane sums and their combined sum through a valid/ready handshake to the next pipeline stage.

Parameters:
- LANE_W, 19: width of each DSP lane output.
- ACC_W, 24: accumulator width per lane; must be greater than LANE_W.
- CNT_W, 8: width of the frame-length field and the sample counter.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- z_in, input, 2*LANE_W: packed DSP output; lane 1 = [2*LANE_W-1:LANE_W], lane 2 = [LANE_W-1:0].
- in_valid, input, 1: z_in carries a product this cycle; upstream control asserts it aligned to the DSP input-register latency.
- in_ready, output, 1: block accepts a sample this cycle.
- signed_mode, input, 1: 1 = lanes are two's complement; 0 = lanes are unsigned. Sampled on the first sample of each frame.
- frame_len, input, CNT_W: samples per frame. Sampled on the first sample of each frame. Value 0 is treated as 1.
- clear, input, 1: synchronous abort/flush.
- acc1_out, output, ACC_W: lane 1 frame sum.
- acc2_out, output, ACC_W: lane 2 frame sum.
- sum_out, output, ACC_W+1: acc1_out + acc2_out, computed at full width with no saturation.
- ovf1, output, 1: lane 1 saturated at least once in the frame.
- ovf2, output, 1: lane 2 saturated at least once in the frame.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- overrun, output, 1: sticky flag; in_valid was asserted while in_ready was 0.

Behaviour:
- Reset (reset = 0, asynchronous): all outputs, accumulators, counter, latched mode and latched length go to 0; state = IDLE; in_ready = 1 after release.
- States:
  - IDLE: waiting for the first sample of a frame.
  - ACCUM: collecting the remaining samples.
  - HOLD: result presented on the outputs.
- in_ready = (state != HOLD) or out_ready.
- Lane extension: each lane is sign-extended (latched signed_mode = 1) or zero-extended (= 0) to ACC_W.
- IDLE, in_valid accepted:
  - Latch signed_mode and max(frame_len, 1).
  - acc = extended lane value; count = 1; ovf cleared.
  - Next state: HOLD if the latched length is 1, else ACCUM.
- ACCUM, in_valid accepted:
  - acc = sat(acc + extended lane value); count increments.
  - When count reaches the latched length, next state = HOLD.
  - Cycles with in_valid = 0 leave all state unchanged.
- Saturation:
  - Signed: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned: clamp to [0, 2^ACC_W-1].
  - Any clamp sets the lane's ovf, which stays set until the next frame start.
- HOLD:
  - out_valid = 1; acc1_out, acc2_out, sum_out, ovf1, ovf2 are registered and held stable until the transfer.
  - out_valid and out_ready transfer the result.
  - If in_valid is also high in the transfer cycle, that sample starts a new frame (same as the IDLE load): zero-bubble back-to-back frames.
  - Otherwise next state = IDLE and out_valid = 0.
- Latency: last sample accepted at edge N gives out_valid = 1 after edge N.
- sum_out: registered together with the accumulators; a combinational sum of the held registers is also acceptable.
- clear (synchronous):
  - Highest priority: overrides in_valid and any out_valid/out_ready transfer in the same cycle.
  - Next cycle: state = IDLE, accumulators = 0, count = 0, out_valid = 0, ovf = 0, overrun = 0.
- overrun: set when in_valid = 1 and in_ready = 0; the sample is dropped. Cleared only by clear or reset.
- frame_len and signed_mode changes mid-frame have no effect until the next frame start.
- Reset asserted mid-frame discards the partial frame; no output is produced.

Test Plan:
- Unsigned, frame_len = 4, lane 1 = 0x00003 and lane 2 = 0x00010 for 4 samples -> out_valid one cycle after the 4th sample; acc1 = 12, acc2 = 64, sum_out = 76, ovf = 0.
- Signed, frame_len = 2, lane 1 = 0x7FFFF (-1) then 0x40000 (-262144) -> acc1 = 0xFBFFFF (-262145); lane 2 = 0x3FFFF twice -> acc2 = 524286.
- Saturation, ACC_W = 24, unsigned, frame_len = 40, lane 1 = 0x7FFFF each sample -> acc1 = 0xFFFFFF, ovf1 = 1; lane 2 = 0 -> ovf2 = 0.
- Back-pressure: out_ready = 0 for 5 cycles in HOLD with in_valid = 1 -> outputs stable, in_ready = 0, overrun = 1. Then out_ready = 1 with in_valid = 1 -> transfer and new-frame load in the same cycle, no bubble.
- frame_len = 0 -> every accepted sample produces its own result (length treated as 1); with continuous in_valid and out_ready = 1, out_valid stays high every cycle.
- clear asserted mid-frame (after 2 of 4 samples) together with in_valid -> next cycle IDLE, accumulators 0, out_valid 0. Separately, reset pulsed low mid-frame -> outputs 0 immediately, asynchronously.
